// File: rtl/turbo_pkg.sv
// Shared constants, read-FSM state type and block-length helper for the
// turbo encoder ping-pong output stage.
package turbo_pkg;

   localparam int unsigned K_SHORT = 1056;
   localparam int unsigned K_LONG  = 6144;
   localparam int unsigned TAIL    = 4;
   localparam int unsigned NSTREAM = 3;

   // TAIL is taken by the tail-length constant, so the read states carry a prefix.
   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_DATA = 2'd1,
      RD_TAIL = 2'd2
   } rd_state_t;

   function automatic int unsigned k_of(input logic len,
                                        input int unsigned k_short,
                                        input int unsigned k_long);
      return len ? k_long : k_short;
   endfunction

endpackage

// File: rtl/turbo_bank_ram.sv
// Simple dual-port bank: one write port, one enabled read port with a
// registered (1-cycle) read data output that holds while re_i is low.
module turbo_bank_ram #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned W     = 3,
   parameter int unsigned AW    = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);

   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= {W{1'b0}};
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/turbo_pingpong_serializer.sv
// Ping-pong output stage: one bank captures a block (data + trellis tail)
// while the other drains to a backpressured serial port with block markers.
module turbo_pingpong_serializer #(
   parameter int unsigned K_SHORT = turbo_pkg::K_SHORT,
   parameter int unsigned K_LONG  = turbo_pkg::K_LONG,
   parameter int unsigned TAIL    = turbo_pkg::TAIL,
   parameter int unsigned NSTREAM = turbo_pkg::NSTREAM
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               in_valid_i,
   input  logic [NSTREAM-1:0] in_d_i,
   input  logic               in_tail_i,
   input  logic               in_len_i,
   input  logic               out_ready_i,
   output logic               out_valid_o,
   output logic [NSTREAM-1:0] out_d_o,
   output logic               out_tail_o,
   output logic               out_sob_o,
   output logic               out_eob_o,
   output logic               out_len_o,
   output logic [1:0]         bank_full_o,
   output logic               overflow_o,
   output logic               frame_err_o
);
   import turbo_pkg::*;

   localparam int unsigned   DEPTH  = K_LONG + TAIL;
   localparam int unsigned   AW     = $clog2(DEPTH);
   localparam int unsigned   CW     = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] ZERO_W = {CW{1'b0}};
   localparam logic [CW-1:0] ONE_W  = CW'(32'd1);
   localparam logic [CW-1:0] TAIL_W = CW'(TAIL);

   logic [1:0]    bank_full_q, bank_full_d, len_q, len_d, clr_mask_s, set_mask_s;
   logic          wr_bank_q, wr_bank_d, overflow_q, overflow_d, frame_err_q, frame_err_d;
   logic [CW-1:0] wr_cnt_q, wr_cnt_d, wr_k_s;
   logic          wr_accept_s, wr_len_s, wr_last_s, wr_done_s;

   rd_state_t     state_q, state_d;
   logic          rd_bank_q, rd_bank_d, rd_en_s, rd_sel_s, rd_clr_s, advance_s;
   logic [CW-1:0] rd_cnt_q, rd_cnt_d, rd_pos_s, rd_k_s, sel_k_s;
   logic [NSTREAM-1:0] rd_data0_s, rd_data1_s;
   logic          out_valid_q, out_tail_q, out_sob_q, out_eob_q, out_len_q, out_bank_q;

   // Length is taken from in_len on the first beat, from the latched flag afterwards.
   always_comb begin
      wr_accept_s = in_valid_i & ~bank_full_q[wr_bank_q];
      if (wr_cnt_q == ZERO_W) begin
         wr_len_s = in_len_i;
      end else begin
         wr_len_s = len_q[wr_bank_q];
      end
      wr_k_s      = CW'(k_of(wr_len_s, K_SHORT, K_LONG));
      wr_last_s   = (wr_cnt_q == wr_k_s + TAIL_W - ONE_W);
      wr_bank_d   = wr_bank_q;
      wr_cnt_d    = wr_cnt_q;
      len_d       = len_q;
      overflow_d  = overflow_q;
      frame_err_d = frame_err_q;
      wr_done_s   = 1'b0;
      if (wr_accept_s) begin
         len_d[wr_bank_q] = wr_len_s;
         frame_err_d      = frame_err_q | (in_tail_i ^ (wr_cnt_q >= wr_k_s));
         if (wr_last_s) begin
            wr_done_s = 1'b1;
            wr_bank_d = ~wr_bank_q;
            wr_cnt_d  = ZERO_W;
         end else begin
            wr_cnt_d  = wr_cnt_q + ONE_W;
         end
      end else if (in_valid_i) begin
         overflow_d = 1'b1;
      end else begin
         overflow_d = overflow_q;
      end
   end

   // Writer and reader always touch opposite banks, so set and clear never collide.
   always_comb begin
      clr_mask_s  = rd_clr_s  ? (2'b01 << rd_bank_q) : 2'b00;
      set_mask_s  = wr_done_s ? (2'b01 << wr_bank_q) : 2'b00;
      bank_full_d = (bank_full_q & ~clr_mask_s) | set_mask_s;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bank_full_q <= 2'b00;
         len_q       <= 2'b00;
         wr_bank_q   <= 1'b0;
         wr_cnt_q    <= ZERO_W;
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         bank_full_q <= bank_full_d;
         len_q       <= len_d;
         wr_bank_q   <= wr_bank_d;
         wr_cnt_q    <= wr_cnt_d;
         overflow_q  <= overflow_d;
         frame_err_q <= frame_err_d;
      end
   end

   // rd_cnt is the next position to fetch; K+TAIL means the eob beat sits in the output.
   always_comb begin
      advance_s = out_ready_i | ~out_valid_q;
      rd_k_s    = CW'(k_of(len_q[rd_bank_q], K_SHORT, K_LONG));
      state_d   = state_q;
      rd_cnt_d  = rd_cnt_q;
      rd_bank_d = rd_bank_q;
      rd_en_s   = 1'b0;
      rd_sel_s  = rd_bank_q;
      rd_pos_s  = rd_cnt_q;
      rd_clr_s  = 1'b0;
      case (state_q)
         RD_IDLE: begin
            if (bank_full_q[rd_bank_q]) begin
               state_d  = RD_DATA;
               rd_cnt_d = ZERO_W;
            end else begin
               state_d  = RD_IDLE;
            end
         end
         RD_DATA: begin
            if (advance_s) begin
               rd_en_s  = 1'b1;
               rd_cnt_d = rd_cnt_q + ONE_W;
               if (rd_cnt_q + ONE_W >= rd_k_s) begin
                  state_d = RD_TAIL;
               end else begin
                  state_d = RD_DATA;
               end
            end else begin
               state_d = RD_DATA;
            end
         end
         RD_TAIL: begin
            if (advance_s && (rd_cnt_q == rd_k_s + TAIL_W)) begin
               rd_clr_s  = 1'b1;
               rd_bank_d = ~rd_bank_q;
               if (bank_full_q[~rd_bank_q]) begin
                  rd_en_s  = 1'b1;
                  rd_sel_s = ~rd_bank_q;
                  rd_pos_s = ZERO_W;
                  rd_cnt_d = ONE_W;
                  state_d  = RD_DATA;
               end else begin
                  rd_cnt_d = ZERO_W;
                  state_d  = RD_IDLE;
               end
            end else if (advance_s) begin
               rd_en_s  = 1'b1;
               rd_cnt_d = rd_cnt_q + ONE_W;
            end else begin
               state_d  = RD_TAIL;
            end
         end
         default: begin
            state_d = RD_IDLE;
         end
      endcase
      sel_k_s = CW'(k_of(len_q[rd_sel_s], K_SHORT, K_LONG));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= RD_IDLE;
         rd_cnt_q  <= ZERO_W;
         rd_bank_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_cnt_q  <= rd_cnt_d;
         rd_bank_q <= rd_bank_d;
      end
   end

   // Output register doubles as the skid word: it only moves when it may advance.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid_q <= 1'b0;
         out_tail_q  <= 1'b0;
         out_sob_q   <= 1'b0;
         out_eob_q   <= 1'b0;
         out_len_q   <= 1'b0;
         out_bank_q  <= 1'b0;
      end else if (advance_s) begin
         out_valid_q <= rd_en_s;
         out_tail_q  <= rd_en_s & (rd_pos_s >= sel_k_s);
         out_sob_q   <= rd_en_s & (rd_pos_s == ZERO_W);
         out_eob_q   <= rd_en_s & (rd_pos_s == sel_k_s + TAIL_W - ONE_W);
         if (rd_en_s) begin
            out_len_q  <= len_q[rd_sel_s];
            out_bank_q <= rd_sel_s;
         end
      end
   end

   turbo_bank_ram #(.DEPTH(DEPTH), .W(NSTREAM), .AW(AW)) u_bank0 (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .we_i    (wr_accept_s & ~wr_bank_q),
      .waddr_i (wr_cnt_q[AW-1:0]),
      .wdata_i (in_d_i),
      .re_i    (rd_en_s & ~rd_sel_s),
      .raddr_i (rd_pos_s[AW-1:0]),
      .rdata_o (rd_data0_s)
   );

   turbo_bank_ram #(.DEPTH(DEPTH), .W(NSTREAM), .AW(AW)) u_bank1 (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .we_i    (wr_accept_s & wr_bank_q),
      .waddr_i (wr_cnt_q[AW-1:0]),
      .wdata_i (in_d_i),
      .re_i    (rd_en_s & rd_sel_s),
      .raddr_i (rd_pos_s[AW-1:0]),
      .rdata_o (rd_data1_s)
   );

   assign out_d_o     = out_bank_q ? rd_data1_s : rd_data0_s;
   assign out_valid_o = out_valid_q;
   assign out_tail_o  = out_tail_q;
   assign out_sob_o   = out_sob_q;
   assign out_eob_o   = out_eob_q;
   assign out_len_o   = out_len_q;
   assign bank_full_o = bank_full_q;
   assign overflow_o  = overflow_q;
   assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_turbo_pingpong_serializer.sv
// Directed bench for the ping-pong serializer (K_SHORT=4, K_LONG=6, TAIL=4):
// expected beats are queued as blocks are written and checked as they are accepted.
module tb_turbo_pingpong_serializer;

   logic       clk, rst_n;
   logic       in_valid, in_tail, in_len, out_ready;
   logic [2:0] in_d, out_d;
   logic       out_valid, out_tail, out_sob, out_eob, out_len, overflow, frame_err;
   logic [1:0] bank_full;

   int         n_vec = 0;
   int         n_err = 0;
   int         eob_cnt = 0;
   int         e0;
   int         w;
   logic [6:0] sb[$];
   logic [6:0] exp_w;
   logic [2:0] prev_d;
   logic       prev_eob;
   bit         stall_prev;

   turbo_pingpong_serializer #(.K_SHORT(4), .K_LONG(6), .TAIL(4), .NSTREAM(3)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (in_valid),
      .in_d_i      (in_d),
      .in_tail_i   (in_tail),
      .in_len_i    (in_len),
      .out_ready_i (out_ready),
      .out_valid_o (out_valid),
      .out_d_o     (out_d),
      .out_tail_o  (out_tail),
      .out_sob_o   (out_sob),
      .out_eob_o   (out_eob),
      .out_len_o   (out_len),
      .bank_full_o (bank_full),
      .overflow_o  (overflow),
      .frame_err_o (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Beat i of a block: data base+i, tail by position unless i == err_pos.
   task automatic write_block(input logic len, input logic [2:0] base, input int err_pos,
                              input bit expect_out);
      int k;
      k = len ? 6 : 4;
      for (int i = 0; i < k + 4; i++) begin
         in_valid = 1'b1;
         in_len   = len;
         in_d     = base + 3'(i);
         in_tail  = (i >= k) ^ (i == err_pos);
         if (expect_out) sb.push_back({in_d, (i >= k), (i == 0), (i == k + 3), len});
         tick();
      end
      in_valid = 1'b0;
      in_tail  = 1'b0;
   endtask

   task automatic drain(input int max);
      int n;
      n = 0;
      while (sb.size() != 0 && n < max) begin
         tick();
         n++;
      end
      check("drain", sb.size(), 0);
      tick();
      tick();
   endtask

   // Output monitor: hold-under-stall and scoreboard compare on each handshake.
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("hold_valid", out_valid, 1);
            check("hold_d", out_d, prev_d);
            check("hold_eob", out_eob, prev_eob);
         end
         if (out_valid && out_ready) begin
            check("spurious_beat", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               exp_w = sb.pop_front();
               check("beat", {out_d, out_tail, out_sob, out_eob, out_len}, exp_w);
            end
            if (out_eob) eob_cnt++;
         end
         stall_prev = out_valid && !out_ready;
         prev_d     = out_d;
         prev_eob   = out_eob;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_d = 3'd0; in_tail = 1'b0; in_len = 1'b0; out_ready = 1'b1;
      tick(); tick();
      check("rst_valid", out_valid, 0);
      check("rst_d", out_d, 0);
      check("rst_tail", out_tail, 0);
      check("rst_sob", out_sob, 0);
      check("rst_eob", out_eob, 0);
      check("rst_len", out_len, 0);
      check("rst_full", bank_full, 0);
      check("rst_ovf", overflow, 0);
      check("rst_ferr", frame_err, 0);
      rst_n = 1'b1;
      tick();

      // 1: short block, first-beat latency
      write_block(1'b0, 3'd1, -1, 1'b1);
      check("t1_full", bank_full, 2'b01);
      check("t1_valid_e0", out_valid, 0);
      tick();
      check("t1_valid_e1", out_valid, 0);
      tick();
      check("t1_valid_e2", out_valid, 1);
      drain(30);

      // 2: long then short, back-to-back with no bubble
      out_ready = 1'b1;
      fork
         begin
            write_block(1'b1, 3'd0, -1, 1'b1);
            write_block(1'b0, 3'd2, -1, 1'b1);
         end
         begin
            w = 0;
            while (!out_valid && w < 40) begin
               tick();
               w++;
            end
            check("t2_start", out_valid, 1);
            for (int i = 1; i < 18; i++) begin
               tick();
               check("t2_nogap", out_valid, 1);
            end
         end
      join
      drain(40);

      // 3: out_ready pattern 1,0,0,1
      out_ready = 1'b0;
      write_block(1'b0, 3'd3, -1, 1'b1);
      for (int c = 0; c < 80; c++) begin
         if (sb.size() == 0) break;
         out_ready = ((c % 4) == 0) || ((c % 4) == 3);
         tick();
      end
      out_ready = 1'b1;
      drain(20);

      // 4: both banks full, third block dropped
      out_ready = 1'b0;
      write_block(1'b1, 3'd2, -1, 1'b1);
      write_block(1'b0, 3'd5, -1, 1'b1);
      check("t4_full2", bank_full, 2'b11);
      check("t4_ovf_pre", overflow, 0);
      write_block(1'b0, 3'd7, -1, 1'b0);
      check("t4_ovf", overflow, 1);
      check("t4_full3", bank_full, 2'b11);
      e0 = eob_cnt;
      out_ready = 1'b1;
      drain(80);
      repeat (20) tick();
      check("t4_blocks", eob_cnt - e0, 2);
      check("t4_empty", bank_full, 2'b00);

      // 5: in_tail asserted on data position 2
      check("t5_ferr_pre", frame_err, 0);
      write_block(1'b0, 3'd4, 2, 1'b1);
      check("t5_ferr", frame_err, 1);
      drain(30);

      // 6: reset mid-read, then a fresh block
      write_block(1'b1, 3'd6, -1, 1'b1);
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      check("t6_valid", out_valid, 0);
      check("t6_full", bank_full, 0);
      check("t6_ovf", overflow, 0);
      check("t6_ferr", frame_err, 0);
      sb.delete();
      tick();
      rst_n = 1'b1;
      tick();
      write_block(1'b0, 3'd1, -1, 1'b1);
      drain(30);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
